// File: rtl/bch_chien_search_pkg.sv
// Shared definitions for the serial BCH Chien search.
// Holds:
//   - the packed BCH parameter word and its field extractors (M, T, N, derived widths);
//   - the scan FSM state type;
//   - GF(2^M) helpers: the primitive polynomial lookup keyed by M, multiply-by-alpha,
//     and alpha^j.
// The helpers are evaluated at elaboration time to build constant multipliers.
package bch_chien_search_pkg;

    // Parameter word layout: [7:0] = M, [15:8] = T, [31:16] = N.
    typedef logic [31:0] bch_param_t;

    // Default parameter word: M = 4, T = 2, N = 15.
    localparam bch_param_t BCH_SANE = {16'd15, 8'd2, 8'd4};

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StScan,
        StReport
    } chien_state_e;

    function automatic int unsigned bch_m(input bch_param_t p);
        return {24'd0, p[7:0]};
    endfunction

    function automatic int unsigned bch_t(input bch_param_t p);
        return {24'd0, p[15:8]};
    endfunction

    function automatic int unsigned bch_n(input bch_param_t p);
        return {16'd0, p[31:16]};
    endfunction

    // sigma_0..sigma_T, M bits each.
    function automatic int unsigned bch_sigma_sz(input bch_param_t p);
        return (bch_t(p) + 1) * bch_m(p);
    endfunction

    // Wide enough that the all-ones value exceeds T, so a saturated count is never legal.
    function automatic int unsigned bch_err_sz(input bch_param_t p);
        return $clog2(bch_t(p) + 2);
    endfunction

    // Primitive polynomial (including the x^M term) for each supported field size.
    function automatic logic [31:0] gf_prim(input int unsigned m);
        logic [31:0] poly;
        case (m)
            2:       poly = 32'h7;
            3:       poly = 32'hB;
            4:       poly = 32'h13;
            5:       poly = 32'h25;
            6:       poly = 32'h43;
            7:       poly = 32'h89;
            8:       poly = 32'h11D;
            9:       poly = 32'h211;
            10:      poly = 32'h409;
            11:      poly = 32'h805;
            12:      poly = 32'h1053;
            13:      poly = 32'h201B;
            14:      poly = 32'h4443;
            15:      poly = 32'h8003;
            16:      poly = 32'h1100B;
            default: poly = 32'h13;
        endcase
        return poly;
    endfunction

    function automatic logic [31:0] gf_mul_alpha(input logic [31:0] x, input int unsigned m);
        logic [31:0] y;
        y = x << 1;
        if (y[m]) begin
            y = y ^ gf_prim(m);
        end
        return y;
    endfunction

    // alpha^j, exponent reduced modulo the multiplicative group order 2^M - 1.
    function automatic logic [31:0] gf_alpha_pow(input int unsigned j, input int unsigned m);
        logic [31:0]  x;
        int unsigned  e;
        x = 32'd1;
        e = j % ((32'd1 << m) - 32'd1);
        for (int unsigned i = 0; i < e; i++) begin
            x = gf_mul_alpha(x, m);
        end
        return x;
    endfunction

endpackage

// File: rtl/bch_chien_term.sv
// One Chien term register r_i for term index Idx.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   load         - r_i <= coef * alpha^(Idx*(2^M - N))  (aligns the scan to degree N-1)
//   step         - r_i <= r_i * alpha^Idx               (advance one codeword position)
//   coef         - sigma_Idx
//   term         - current r_i
// Both multipliers are by constants, so each is an XOR network: column b of the
// matrix is alpha^(exp + b), selected by input bit b.
module bch_chien_term
    import bch_chien_search_pkg::*;
#(
    parameter bch_param_t  P   = BCH_SANE,
    parameter int unsigned Idx = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [bch_m(P)-1:0]  coef,
    output logic [bch_m(P)-1:0]  term
);

    localparam int unsigned M       = bch_m(P);
    localparam int unsigned N       = bch_n(P);
    localparam int unsigned Order   = (32'd1 << M) - 32'd1;
    localparam int unsigned LoadExp = (Idx * ((32'd1 << M) - N)) % Order;

    logic [M-1:0] load_cols [M];
    logic [M-1:0] step_cols [M];
    logic [M-1:0] load_val;
    logic [M-1:0] step_val;

    for (genvar b = 0; b < M; b++) begin : g_col
        localparam logic [31:0] LoadCol = gf_alpha_pow(LoadExp + b, M);
        localparam logic [31:0] StepCol = gf_alpha_pow(Idx + b, M);
        assign load_cols[b] = LoadCol[M-1:0];
        assign step_cols[b] = StepCol[M-1:0];
    end

    always_comb begin
        load_val = '0;
        step_val = '0;
        for (int unsigned b = 0; b < M; b++) begin
            if (coef[b]) begin
                load_val = load_val ^ load_cols[b];
            end
            if (term[b]) begin
                step_val = step_val ^ step_cols[b];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            term <= '0;
        end else if (load) begin
            term <= load_val;
        end else if (step) begin
            term <= step_val;
        end
    end

endmodule

// File: rtl/bch_chien_search.sv
// Serial Chien search: evaluates the error-locator polynomial at every codeword
// position, first transmitted bit (degree N-1) first, one position per transfer.
// Ports:
//   clk, reset_n        - clock and asynchronous active-low reset
//   start               - sigma/err_count valid; taken in IDLE, or in REPORT with accepted
//   sigma               - sigma_0..sigma_T, sigma_0 in LSBs (sigma_0 assumed to be 1)
//   err_count           - degree claimed by the solver
//   busy                - cannot accept start
//   err/err_valid/err_ready/err_first/err_last - per-bit error-flag stream
//   done/accepted       - status handshake; done held until accepted
//   root_count          - positions flagged (saturating)
//   fail                - root_count != err_count, or the count saturated
// The stream has a one-entry registered output stage: the term registers always hold
// the position after the one on err, so err never depends combinationally on err_ready.
module bch_chien_search
    import bch_chien_search_pkg::*;
#(
    parameter bch_param_t P = BCH_SANE
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [bch_sigma_sz(P)-1:0] sigma,
    input  logic [bch_err_sz(P)-1:0]   err_count,
    output logic                       busy,
    output logic                       err,
    output logic                       err_valid,
    input  logic                       err_ready,
    output logic                       err_first,
    output logic                       err_last,
    output logic                       done,
    input  logic                       accepted,
    output logic [bch_err_sz(P)-1:0]   root_count,
    output logic                       fail
);

    localparam int unsigned M       = bch_m(P);
    localparam int unsigned T       = bch_t(P);
    localparam int unsigned N       = bch_n(P);
    localparam int unsigned SigmaSz = bch_sigma_sz(P);
    localparam int unsigned ErrSz   = bch_err_sz(P);
    localparam int unsigned KWidth  = (N > 1) ? $clog2(N) : 1;

    localparam logic [KWidth-1:0] LastK    = KWidth'(N - 1);
    localparam logic [ErrSz-1:0]  RootMax  = '1;

    chien_state_e state_q, state_d;

    logic [T*M-1:0]    coef_q;
    logic [ErrSz-1:0]  err_count_q;
    logic [ErrSz-1:0]  root_count_q;
    logic [KWidth-1:0] gen_k_q;     // index of the next position to present
    logic              gen_more_q;  // positions remain to be presented
    logic              err_q;
    logic              err_valid_q;
    logic              err_first_q;
    logic              err_last_q;

    logic              take_start;
    logic              load_terms;
    logic              xfer;
    logic              gen;
    logic [M-1:0]      terms [T];
    logic [M-1:0]      sum;

    // sigma_0 is assumed normalised to 1 and is not stored.
    logic unused_sigma0;
    assign unused_sigma0 = ^sigma[M-1:0];

    assign load_terms = (state_q == StLoad);
    assign xfer       = err_valid_q && err_ready;
    // Refill the output stage when it is empty or being drained this cycle.
    assign gen        = (state_q == StScan) && gen_more_q && (!err_valid_q || err_ready);

    for (genvar gi = 0; gi < T; gi++) begin : g_term
        bch_chien_term #(
            .P   (P),
            .Idx (gi + 1)
        ) u_term (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load_terms),
            .step    (gen),
            .coef    (coef_q[gi*M +: M]),
            .term    (terms[gi])
        );
    end

    always_comb begin
        sum = M'(1);
        for (int unsigned i = 0; i < T; i++) begin
            sum = sum ^ terms[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        take_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    take_start = 1'b1;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                state_d = StScan;
            end
            StScan: begin
                if (xfer && err_last_q) begin
                    state_d = StReport;
                end
            end
            StReport: begin
                // A start alongside accepted chains straight into the next codeword.
                if (accepted) begin
                    if (start) begin
                        take_start = 1'b1;
                        state_d    = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coef_q       <= '0;
            err_count_q  <= '0;
            root_count_q <= '0;
            gen_k_q      <= '0;
            gen_more_q   <= 1'b0;
            err_q        <= 1'b0;
            err_valid_q  <= 1'b0;
            err_first_q  <= 1'b0;
            err_last_q   <= 1'b0;
        end else begin
            if (take_start) begin
                coef_q       <= sigma[SigmaSz-1:M];
                err_count_q  <= err_count;
                root_count_q <= '0;
            end else if (xfer && err_q && (root_count_q != RootMax)) begin
                root_count_q <= root_count_q + ErrSz'(1);
            end

            if (load_terms) begin
                gen_k_q    <= '0;
                gen_more_q <= 1'b1;
            end else if (gen) begin
                gen_k_q <= gen_k_q + KWidth'(1);
                if (gen_k_q == LastK) begin
                    gen_more_q <= 1'b0;
                end
            end

            if (gen) begin
                err_valid_q <= 1'b1;
                err_q       <= (sum == '0);
                err_first_q <= (gen_k_q == '0);
                err_last_q  <= (gen_k_q == LastK);
            end else if (xfer) begin
                err_valid_q <= 1'b0;
                err_q       <= 1'b0;
                err_first_q <= 1'b0;
                err_last_q  <= 1'b0;
            end
        end
    end

    assign err        = err_q;
    assign err_valid  = err_valid_q;
    assign err_first  = err_first_q;
    assign err_last   = err_last_q;
    assign root_count = root_count_q;
    assign done       = (state_q == StReport);
    assign busy       = (state_q != StIdle) || (done && !accepted);
    assign fail       = done && ((root_count_q != err_count_q) || (root_count_q == RootMax));

endmodule

// File: tb/tb_bch_chien_search.sv
module tb_bch_chien_search;
    import bch_chien_search_pkg::*;

    localparam bch_param_t TbP = {16'd15, 8'd2, 8'd4};

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [11:0] sigma;
    logic [1:0]  err_count;
    logic        busy;
    logic        err;
    logic        err_valid;
    logic        err_ready;
    logic        err_first;
    logic        err_last;
    logic        done;
    logic        accepted;
    logic [1:0]  root_count;
    logic        fail;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [11:0] sigma;
        logic [1:0]  ec;
        logic [14:0] exp_mask;   // bit k = expected err at stream index k
        logic [1:0]  exp_roots;
        logic        exp_fail;
        int          ready_pct;
    } vec_t;

    vec_t vecs [5];

    bch_chien_search #(
        .P (TbP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .sigma      (sigma),
        .err_count  (err_count),
        .busy       (busy),
        .err        (err),
        .err_valid  (err_valid),
        .err_ready  (err_ready),
        .err_first  (err_first),
        .err_last   (err_last),
        .done       (done),
        .accepted   (accepted),
        .root_count (root_count),
        .fail       (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input int id, input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL case%0d %s: got %0h expected %0h", id, nm, got, exp);
        end
    endtask

    // Pulse start; returns at the negedge just after the accepting edge (e = 0).
    task automatic start_vec(input vec_t v, input int id);
        @(negedge clk);
        sigma     = v.sigma;
        err_count = v.ec;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check(id, "busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Drain the stream until done, with a start poke mid-scan that must be ignored.
    task automatic scan_vec(input vec_t v, input int id);
        logic [14:0] got;
        int          k;
        int          e;
        int          done_e;
        bit          frame_ok;
        bit          freeze_ok;
        bit          stalled;
        logic        h_err;
        logic        h_first;
        logic        h_last;
        got = '0; k = 0; e = 0; done_e = -1;
        frame_ok = 1'b1; freeze_ok = 1'b1; stalled = 1'b0;
        h_err = 1'b0; h_first = 1'b0; h_last = 1'b0;
        while (done_e < 0 && e < 2000) begin
            if (stalled && (err_valid !== 1'b1 || err !== h_err || err_first !== h_first ||
                            err_last !== h_last)) begin
                freeze_ok = 1'b0;
            end
            stalled = 1'b0;
            if (done === 1'b1) begin
                done_e = e;
            end else begin
                start = (e == 6);
                if (e == 6) begin
                    sigma     = 12'hFFF;
                    err_count = 2'd3;
                end
                err_ready = (int'($urandom_range(99)) < v.ready_pct);
                if (err_valid === 1'b1) begin
                    if (err_ready) begin
                        if (k < 15) got[k] = err;
                        if (err_first !== (k == 0)) frame_ok = 1'b0;
                        if (err_last !== (k == 14)) frame_ok = 1'b0;
                        k++;
                    end else begin
                        stalled = 1'b1;
                        h_err   = err;
                        h_first = err_first;
                        h_last  = err_last;
                    end
                end
                @(negedge clk);
                e++;
            end
        end
        start     = 1'b0;
        err_ready = 1'b0;
        check(id, "done_seen", {31'd0, done_e >= 0}, 32'd1);
        check(id, "stream", {17'd0, got}, {17'd0, v.exp_mask});
        check(id, "bit_count", k, 15);
        check(id, "framing", {31'd0, frame_ok}, 32'd1);
        check(id, "stall_freeze", {31'd0, freeze_ok}, 32'd1);
        check(id, "root_count", {30'd0, root_count}, {30'd0, v.exp_roots});
        check(id, "fail", {31'd0, fail}, {31'd0, v.exp_fail});
        check(id, "busy_in_report", {31'd0, busy}, 32'd1);
        if (v.ready_pct == 100) begin
            check(id, "done_latency", done_e, 17);
        end
    endtask

    task automatic accept_only(input int id);
        accepted = 1'b1;
        @(posedge clk);
        @(negedge clk);
        accepted = 1'b0;
        check(id, "idle_after_accept", {29'd0, busy, done, fail}, 32'd0);
    endtask

    initial begin
        vec_t r;
        n_vec = 0; n_bad = 0;
        reset_n = 1'b0; start = 1'b0; sigma = '0; err_count = '0;
        err_ready = 1'b0; accepted = 1'b0;

        // GF(16), x^4+x+1: alpha^3 = 8, alpha^7 = B, alpha^14 = 9, 1+alpha^14 = 8.
        vecs[0] = '{12'h001, 2'd0, 15'h0000, 2'd0, 1'b0, 100};  // no roots
        vecs[1] = '{12'h081, 2'd1, 15'h0800, 2'd1, 1'b0, 100};  // degree 3 -> k = 11
        vecs[2] = '{12'h981, 2'd2, 15'h4001, 2'd2, 1'b0, 100};  // degrees 14, 0 -> k = 0, 14
        vecs[3] = '{12'h081, 2'd2, 15'h0800, 2'd1, 1'b1, 100};  // count mismatch
        vecs[4] = '{12'h0B1, 2'd1, 15'h0080, 2'd1, 1'b0, 30};   // degree 7, stalls

        repeat (3) @(posedge clk);
        @(negedge clk);
        check(99, "reset_state",
              {24'd0, busy, err, err_valid, err_first, err_last, done, fail, 1'b0},
              32'd0);
        check(99, "reset_root_count", {30'd0, root_count}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check(99, "idle_not_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            start_vec(vecs[i], i);
            scan_vec(vecs[i], i);
            accept_only(i);
        end

        // Back-to-back: accepted and start together leave REPORT straight into LOAD.
        start_vec(vecs[2], 5);
        scan_vec(vecs[2], 5);
        sigma     = vecs[1].sigma;
        err_count = vecs[1].ec;
        start     = 1'b1;
        accepted  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        accepted = 1'b0;
        check(6, "chained_busy_done", {30'd0, busy, done}, 32'd2);
        scan_vec(vecs[1], 6);
        accept_only(6);

        // Reset while bit k = 5 is on the stream, then a clean full codeword.
        r = vecs[4];
        r.ready_pct = 100;
        start_vec(r, 7);
        err_ready = 1'b1;
        repeat (7) @(negedge clk);
        check(7, "valid_before_reset", {31'd0, err_valid}, 32'd1);
        check(7, "first_clear_at_k5", {31'd0, err_first}, 32'd0);
        reset_n = 1'b0;
        #1;
        check(7, "reset_outputs",
              {22'd0, busy, err, err_valid, err_first, err_last, done, fail, root_count},
              32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        err_ready = 1'b0;
        start_vec(r, 8);
        scan_vec(r, 8);
        accept_only(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bch_chien_search.md
# bch_chien_search

Serial Chien search stage that sits directly downstream of the Berlekamp–Massey sigma solver. It accepts one error-locator polynomial with its claimed error count and evaluates it at every codeword position, one position per clock. It emits a per-bit error-flag stream, with backpressure, to the correction XOR stage. After the last position it reports the root count and an uncorrectable flag.

## Interface
- P, `BCH_SANE: packed BCH parameter word.
- Derived localparams: M = `BCH_M(P), T = `BCH_T(P), N = `BCH_N(P) (codeword bits scanned).
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  sigma/err_count valid; taken only when !busy.
- sigma  in  `BCH_SIGMA_SZ(P)  coefficients sigma_0..sigma_T, M bits each, sigma_0 in LSBs.
- err_count  in  `BCH_ERR_SZ(P)  degree claimed by the solver.
- busy  out  1  block cannot accept start.
- err  out  1  bit k of the stream is in error.
- err_valid  out  1  err/err_first/err_last are valid.
- err_ready  in  1  downstream accepts the bit.
- err_first, err_last  out  1  mark k = 0 and k = N-1.
- done  out  1  status valid; held until accepted.
- accepted  in  1  status consumed.
- root_count  out  `BCH_ERR_SZ(P)  number of positions flagged.
- fail  out  1  root_count != err_count, or a root count overflow occurred.
- Reset values: busy, err, err_valid, err_first, err_last, done, fail = 0; root_count = 0.

## Operation
- Stream index k = 0..N-1. Bit k corresponds to codeword degree e = N-1-k, i.e. the first transmitted bit comes first. Bit k is in error iff sigma(alpha^-e) = 0.
- Term registers r_1..r_T, M bits each.
  - LOAD: r_i <= sigma_i * alpha^(i*(2^M - N)), a constant multiply.
  - Each transferred bit: r_i <= r_i * alpha^i.
  - sum = 1 XOR r_1 XOR … XOR r_T. The stored sigma_0 is ignored; it is assumed normalised to 1.
- States:
  - IDLE: start && !busy → LOAD. Latch sigma and err_count; clear root_count and fail.
  - LOAD: compute the premultiplied terms → SCAN.
  - SCAN: err_valid = 1, err = (sum == 0). On err_valid && err_ready: advance the terms and k, and increment root_count if err. If k = N-1 on that transfer → REPORT.
  - REPORT: done = 1; fail = (root_count != err_count) || overflow.
- Exit from REPORT:
  - accepted → IDLE.
  - accepted && start in the same cycle → LOAD directly, with no idle bubble.
- busy = (state != IDLE) || (done && !accepted).
- Arithmetic:
  - All field operations are in GF(2^M) with the codebase primitive polynomial.
  - root_count saturates at its maximum; a saturated count forces fail = 1.
- Boundary cases:
  - sigma = 1: no roots. fail = (err_count != 0).
  - err_ready held low: err, err_first, err_last, k and the terms are all frozen.
  - reset_n low mid-scan: immediate return to IDLE with all outputs at their reset values; the partial stream is abandoned.
  - start while busy: ignored, with no latch.

## Timing
- start accepted at edge t.
  - LOAD occupies cycle t+1.
  - First err_valid is high from edge t+2.
- With err_ready tied high: one bit per cycle; err_last at cycle t+1+N; done rises at edge t+2+N.
- Throughput is N+2 cycles per codeword, plus the done→accepted gap.
- err is a registered function of the terms; there is no combinational path from err_ready to err.
- err_valid, err_first and err_last never toggle while err_ready is low.

## Structure
- Shared header (`bch.vh`) holds:
  - constant-multiply-by-alpha^j function;
  - alpha-power function;
  - the primitive polynomial lookup keyed by M.
- Use the `BCH_*` macros from `bch_defs.vh` for all widths.
- Sub-module: bch_chien_term. One M-bit register with a LOAD constant multiplier and a STEP constant multiplier, parameterised by P and term index i. Instantiate T of them.

## Test plan
Bench uses M=4, T=2, N=15.
- sigma = 1, err_count = 0 → 15 bits all 0; root_count = 0; fail = 0; done at t+17.
- sigma = 1 + alpha^3·x, err_count = 1 → only bit k = 11 set; root_count = 1; fail = 0.
- sigma = (1+x)(1+alpha^14·x), err_count = 2 → bits k = 0 and 14 set, err_first and err_last coincide with them; root_count = 2; fail = 0.
- Same sigma as the single-error case with err_count = 2 → root_count = 1; fail = 1.
- Random err_ready duty cycle of 30%, error at degree 7 → identical stream content; err frozen during stalls; bit k = 7 set.
- reset_n asserted at k = 5, then released; new start → all outputs reset immediately; second codeword scans fully, starting from k = 0.
